// File: rtl/mulmod_pkg.sv
// Shared constants for the X25519 field datapath: the modulus and the
// multiplier's state encodings.
package mulmod_pkg;

    localparam logic [254:0] P25519 = ~255'd0 - 255'd18;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] CNT_TOP = 8'd254;

endpackage

// File: rtl/mulmod_addmod.sv
// Combinational modular adder: s = (x + y) mod P25519 for x, y < P25519.
module addmod
    import mulmod_pkg::*;
(
    input  logic [254:0] x,
    input  logic [254:0] y,
    output logic [254:0] s
);

    logic [255:0] w_sum;
    logic [254:0] w_diff;
    logic         w_ge_p;

    assign w_sum  = {1'b0, x} + {1'b0, y};
    // When w_sum >= p the true difference is < p, so 255 bits hold it exactly.
    assign w_diff = w_sum[254:0] - P25519;
    assign w_ge_p = (w_sum >= {1'b0, P25519});

    // Select the reduced or unreduced sum.
    always_comb begin
        if (w_ge_p) begin
            s = w_diff;
        end else begin
            s = w_sum[254:0];
        end
    end

endmodule

// File: rtl/mulmod.sv
// Sequential modular multiplier over GF(2^255-19): MSB-first interleaved
// double-and-add, one operand bit per cycle, fixed 256-cycle latency.
module mulmod
    import mulmod_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic         busy,
    output logic         done,
    output logic [254:0] z
);

    logic [1:0]   r_state;
    logic [7:0]   r_cnt;
    logic [254:0] r_ra;
    logic [254:0] r_rb;
    logic [254:0] r_acc;
    logic         r_busy;
    logic         r_done;

    logic [254:0] w_dbl;
    logic [254:0] w_addend;
    logic [254:0] w_next;

    addmod u_dbl (
        .x (r_acc),
        .y (r_acc),
        .s (w_dbl)
    );

    // Add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        if (r_rb[r_cnt]) begin
            w_addend = r_ra;
        end else begin
            w_addend = 255'd0;
        end
    end

    addmod u_add (
        .x (w_dbl),
        .y (w_addend),
        .s (w_next)
    );

    // Control FSM together with the operand, counter and accumulator registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_ra    <= 255'd0;
            r_rb    <= 255'd0;
            r_acc   <= 255'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ra    <= a;
                        r_rb    <= b;
                        r_acc   <= 255'd0;
                        r_cnt   <= CNT_TOP;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_next;
                    if (r_cnt == 8'd0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign z    = r_acc;

endmodule
